// File: rtl/display_pkg.sv
// Shared constants for the digit scanner: segment encodings, blank pattern,
// anode polarity and the slot phase type.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic       AN_OFF    = 1'b1;

    // Segments a..g on [6]..[0], active-high; entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,  // F E d C
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,  // b A 9 8
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,  // 7 6 5 4
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110   // 3 2 1 0
    };

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

endpackage

// File: rtl/display_scan_controller_hex7seg.sv
// Registered hex-to-7-segment decoder; output lags the nibble by one cycle.
module hex7seg_reg
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    logic [6:0] seg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) seg_q <= SEG_BLANK;
        else        seg_q <= SEG_HEX[nib_i];
    end

    assign seg_o = seg_q;

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scanner with blanking gaps, leading-zero suppression
// and a frame-synchronous load handshake.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    output logic                    ready,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         disp_q, disp_d, pend_q, pend_d;
    logic                  pend_v_q, pend_v_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  lz_q, lz_d;
    logic                  slot_end, frame_end, accept;
    phase_e                phase_d;
    logic [6:0]            dec_seg;

    always_comb begin
        slot_end  = (cnt_q == CW'(SLOT_CYCLES - 1));
        frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;
        if (slot_end) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);

        // Anodes are registered from the next slot position so they track cnt_q exactly.
        phase_d = (cnt_d < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
        an_d    = {NUM_DIGITS{AN_OFF}};
        if (phase_d == PH_SHOW) an_d[idx_d] = ~AN_OFF;

        accept   = load && ready;
        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (frame_end && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
        end
        if (accept) begin
            pend_d   = value;
            pend_v_d = 1'b1;
        end

        lz_d = blank_lz && (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            disp_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            an_q     <= {NUM_DIGITS{AN_OFF}};
            lz_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            an_q     <= an_d;
            lz_q     <= lz_d;
        end
    end

    hex7seg_reg u_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .nib_i (disp_q[{idx_q, 2'b00} +: 4]),
        .seg_o (dec_seg)
    );

    assign seg        = lz_q ? SEG_BLANK : dec_seg;
    assign an         = an_q;
    assign ready      = ~pend_v_q;
    assign frame_done = frame_end;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomised and directed bench for display_scan_controller against a
// time-indexed reference model of the scan schedule and frame buffer.
module tb_display_scan_controller;

    localparam int N = 4, S = 8, B = 2, F = N * S;

    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, blank_lz = 1'b0;
    logic [15:0] value = '0;
    logic        ready, frame_done;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0, passed = 0;

    // Reference model: time since reset, frame buffers, blank flag as seen by the last edge.
    int          m_t = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    bit          m_pv = 0, m_blz_prev = 0;

    logic [6:0] SEGT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    display_scan_controller #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .ready(ready),
        .blank_lz(blank_lz), .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic int m_cnt(); return m_t % S; endfunction
    function automatic int m_idx(); return (m_t / S) % N; endfunction
    function automatic logic m_fd(); return (m_t % F) == F - 1; endfunction

    function automatic logic [3:0] exp_an();
        if (m_cnt() < B) return 4'hF;
        return ~(4'b0001 << m_idx());
    endfunction

    function automatic logic [6:0] exp_seg();
        logic [15:0] hi;
        hi = m_disp >> (4 * m_idx());
        if (m_blz_prev && m_idx() > 0 && hi == 16'h0) return 7'h00;
        return SEGT[hi[3:0]];
    endfunction

    task automatic tick();
        bit acc;
        @(posedge clk);
        if (!rst_n) begin
            m_t = 0; m_disp = '0; m_pv = 0;
        end else begin
            acc = load && !m_pv;
            if (m_fd() && m_pv) begin m_disp = m_pend; m_pv = 0; end
            if (acc) begin m_pend = value; m_pv = 1; end
            m_blz_prev = blank_lz;
            m_t++;
        end
        @(negedge clk);
    endtask

    task automatic advance_to(input int phase);
        while (m_t % F != phase) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; blank_lz = 1'b0;
        tick(); tick();
        checks++; if (an !== 4'hF) $display("FAIL reset_an got %b exp 1111", an); else passed++;
        checks++; if (seg !== 7'h00) $display("FAIL reset_seg got %b exp 0000000", seg); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_fd got %b exp 0", frame_done); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        for (int i = 0; i < 2 * F; i++) begin
            checks++; if (an !== exp_an()) $display("FAIL idle_an t=%0d got %b exp %b", m_t, an, exp_an()); else passed++;
            checks++; if (frame_done !== m_fd()) $display("FAIL idle_fd t=%0d got %b exp %b", m_t, frame_done, m_fd()); else passed++;
            checks++; if (ready !== 1'b1) $display("FAIL idle_ready t=%0d got %b exp 1", m_t, ready); else passed++;
            if (m_cnt() >= B) begin
                checks++; if (seg !== 7'b1111110) $display("FAIL idle_seg t=%0d got %b exp 1111110", m_t, seg); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_load_midframe();
        logic [6:0] want [4] = '{7'b1111110, 7'b1000111, 7'b1011011, 7'b1110111};
        advance_to(10);
        load = 1'b1; value = 16'hA5F0;
        tick();
        load = 1'b0;
        checks++; if (ready !== 1'b0) $display("FAIL mid_ready_drop got %b exp 0", ready); else passed++;
        while (!m_fd()) begin
            if (m_cnt() >= B) begin
                checks++; if (seg !== 7'b1111110) $display("FAIL mid_old_seg t=%0d got %b exp 1111110", m_t, seg); else passed++;
            end
            tick();
        end
        checks++; if (frame_done !== 1'b1) $display("FAIL mid_fd got %b exp 1", frame_done); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL mid_ready_at_fd got %b exp 0", ready); else passed++;
        tick();
        checks++; if (ready !== 1'b1) $display("FAIL mid_ready_rise got %b exp 1", ready); else passed++;
        for (int i = 0; i < F; i++) begin
            checks++; if (an !== exp_an()) $display("FAIL mid_an t=%0d got %b exp %b", m_t, an, exp_an()); else passed++;
            if (m_cnt() >= B) begin
                checks++; if (seg !== want[m_idx()]) $display("FAIL mid_new_seg d%0d got %b exp %b", m_idx(), seg, want[m_idx()]); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_load_while_busy();
        load = 1'b1; value = 16'h4320;
        tick();
        value = 16'h1111;
        tick();
        load = 1'b0;
        checks++; if (ready !== 1'b0) $display("FAIL busy_ready got %b exp 0", ready); else passed++;
        for (int i = 0; i < 2 * F; i++) begin
            if (m_cnt() >= 1) begin
                checks++; if (seg !== exp_seg()) $display("FAIL busy_seg t=%0d got %b exp %b", m_t, seg, exp_seg()); else passed++;
            end
            if (m_cnt() >= B && seg === 7'b0110000) begin
                checks++; $display("FAIL busy_ignored t=%0d got %b exp not 0110000", m_t, seg);
            end
            tick();
        end
        checks++; if (m_disp !== 16'h4320 || ready !== 1'b1) $display("FAIL busy_final ready=%b exp 1", ready); else passed++;
    endtask

    task automatic test_load_at_frame_done();
        advance_to(F - 1);
        checks++; if (frame_done !== 1'b1) $display("FAIL fdload_fd got %b exp 1", frame_done); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL fdload_ready got %b exp 1", ready); else passed++;
        load = 1'b1; value = 16'h0007;
        tick();
        load = 1'b0;
        for (int i = 0; i < F; i++) begin
            if (m_cnt() >= B && m_idx() == 0) begin
                checks++; if (seg !== 7'b1111110) $display("FAIL fdload_not_yet got %b exp 1111110", seg); else passed++;
            end
            tick();
        end
        for (int i = 0; i < F; i++) begin
            if (m_cnt() >= B) begin
                checks++;
                if (seg !== ((m_idx() == 0) ? 7'b1110000 : 7'b1111110))
                    $display("FAIL fdload_shown d%0d got %b", m_idx(), seg);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_blank_lz();
        logic [6:0] want [4] = '{7'b1111110, 7'b1111001, 7'b0000000, 7'b0000000};
        blank_lz = 1'b1;
        load = 1'b1; value = 16'h0030;
        tick();
        load = 1'b0;
        advance_to(0);
        for (int i = 0; i < F; i++) begin
            checks++; if (an !== exp_an()) $display("FAIL lz_an t=%0d got %b exp %b", m_t, an, exp_an()); else passed++;
            if (m_cnt() >= B) begin
                checks++; if (seg !== want[m_idx()]) $display("FAIL lz_seg d%0d got %b exp %b", m_idx(), seg, want[m_idx()]); else passed++;
            end
            tick();
        end
        load = 1'b1; value = 16'h0000;
        tick();
        load = 1'b0;
        advance_to(0);
        for (int i = 0; i < F; i++) begin
            if (m_cnt() >= B) begin
                checks++;
                if (seg !== ((m_idx() == 0) ? 7'b1111110 : 7'b0000000))
                    $display("FAIL lz_zero d%0d got %b", m_idx(), seg);
                else passed++;
            end
            tick();
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_reset_midframe();
        advance_to(1);
        load = 1'b1; value = 16'h1234;
        tick();
        load = 1'b0;
        advance_to(2 * S + 4);
        checks++; if (an !== 4'b1011) $display("FAIL rstmid_pre_an got %b exp 1011", an); else passed++;
        rst_n = 1'b0;
        tick();
        checks++; if (an !== 4'hF) $display("FAIL rstmid_an got %b exp 1111", an); else passed++;
        checks++; if (seg !== 7'h00) $display("FAIL rstmid_seg got %b exp 0000000", seg); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", ready); else passed++;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * F; i++) begin
            checks++; if (an !== exp_an()) $display("FAIL rstmid_scan_an t=%0d got %b exp %b", m_t, an, exp_an()); else passed++;
            if (m_cnt() >= B) begin
                checks++; if (seg !== 7'b1111110) $display("FAIL rstmid_scan_seg t=%0d got %b exp 1111110", m_t, seg); else passed++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [15:0] masks [4] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};
        for (int i = 0; i < 600; i++) begin
            checks++; if (an !== exp_an()) $display("FAIL rnd_an t=%0d got %b exp %b", m_t, an, exp_an()); else passed++;
            checks++; if (ready !== !m_pv) $display("FAIL rnd_ready t=%0d got %b exp %b", m_t, ready, !m_pv); else passed++;
            checks++; if (frame_done !== m_fd()) $display("FAIL rnd_fd t=%0d got %b exp %b", m_t, frame_done, m_fd()); else passed++;
            if (m_cnt() >= 1) begin
                checks++; if (seg !== exp_seg()) $display("FAIL rnd_seg t=%0d got %b exp %b", m_t, seg, exp_seg()); else passed++;
            end
            load  = ($urandom_range(0, 3) == 0);
            value = 16'($urandom) & masks[$urandom_range(0, 3)];
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load_midframe();
        test_load_while_busy();
        test_load_at_frame_done();
        test_blank_lz();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
